// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions: bus widths, default timeout and FSM states.
package wb_pkg;
  localparam int WB_AW      = 30;
  localparam int WB_DW      = 32;
  localparam int WB_SELW    = 4;
  localparam int WB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter for bus watchdogs; o_tc flags the counting cycle whose
// increment brings the count to TIMEOUT, so TIMEOUT enabled cycles elapse before it fires.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = i_en && !i_clr && (count_q >= CNT_LAST);
endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding pipelined Wishbone B4 initiator: one valid/ready request in,
// one bus transaction out, one-cycle response pulse back (read data or error).
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = WB_TIMEOUT,
  parameter int TW      = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // Request: transfer happens on a rising edge where i_req_valid && o_req_ready;
  // the request fields need only be valid in that cycle.
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [DW-1:0]   i_req_data,
  input  logic [DW/8-1:0] i_req_sel,
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output wb_state_e       o_dbg_state
);
  wb_state_e       state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            ctr_clr, tmo_tc, bus_done;

  wb_timeout_ctr #(.TIMEOUT(TIMEOUT), .TW(TW)) u_tmo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (ctr_clr),
    .i_en    (cyc_q),
    .o_tc    (tmo_tc)
  );

  assign bus_done = i_wb_ack || i_wb_err;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    ctr_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr;
          wdata_d = i_req_data;
          sel_d   = i_req_sel;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          ctr_clr = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST, WAIT_ACK: begin
        // Slave response beats the watchdog, which beats a plain stall release.
        if (bus_done) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_wb_err;
          rsp_data_d  = (!i_wb_err && !we_q) ? i_wb_data : '0;
          state_d     = IDLE;
        end else if (tmo_tc) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = IDLE;
        end else if ((state_q == REQUEST) && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT_ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_req_ready = (state_q == IDLE) && !i_reset;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_wb_sel    = sel_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with TIMEOUT = 16; inputs change and outputs
// are sampled on the falling edge, so each negedge below is one bus cycle.
module tb_wb_master_bridge;
  import wb_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_req_valid, o_req_ready, i_req_we;
  logic [AW-1:0]   i_req_addr;
  logic [DW-1:0]   i_req_data;
  logic [DW/8-1:0] i_req_sel;
  logic            o_rsp_valid, o_rsp_err;
  logic [DW-1:0]   o_rsp_data;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_ack, i_wb_stall, i_wb_err;
  logic [DW-1:0]   i_wb_data;
  wb_state_e       o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] slave_reg;

  wb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(16), .TW(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_sel(i_req_sel),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_step();
    @(negedge i_clk);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_data  = data;
    i_req_sel   = 4'hF;
  endtask

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_req_data = '0; i_req_sel = '0; i_wb_ack = 1'b0; i_wb_stall = 1'b0;
    i_wb_err = 1'b0; i_wb_data = '0; slave_reg = '0;
    repeat (3) cyc_step();
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(o_wb_stb), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_ready_in_reset", 32'(o_req_ready), 32'd0);
    i_reset = 1'b0;
    cyc_step();
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_addr", 32'(o_wb_addr), 32'd0);
    chk("rst_rsp_data", o_rsp_data, 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'(IDLE));

    // Write, zero stall: accept T, stb T+1 only, ack T+2, response T+3.
    issue(1'b1, 30'h10, 32'h00ABCDEF);
    cyc_step();
    i_req_valid = 1'b0;
    chk("wr_cyc", 32'(o_wb_cyc), 32'd1);
    chk("wr_stb", 32'(o_wb_stb), 32'd1);
    chk("wr_we", 32'(o_wb_we), 32'd1);
    chk("wr_addr", 32'(o_wb_addr), 32'h10);
    chk("wr_sel", 32'(o_wb_sel), 32'hF);
    if (o_wb_stb && o_wb_we && !i_wb_stall) slave_reg = o_wb_data;
    cyc_step();
    chk("wr_stb_low", 32'(o_wb_stb), 32'd0);
    chk("wr_cyc_hold", 32'(o_wb_cyc), 32'd1);
    chk("wr_no_rsp_yet", 32'(o_rsp_valid), 32'd0);
    i_wb_ack = 1'b1;
    cyc_step();
    i_wb_ack = 1'b0;
    chk("wr_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("wr_rsp_data", o_rsp_data, 32'd0);
    chk("wr_cyc_done", 32'(o_wb_cyc), 32'd0);
    chk("wr_slave_reg", slave_reg, 32'h00ABCDEF);
    cyc_step();
    chk("wr_rsp_pulse", 32'(o_rsp_valid), 32'd0);

    // Read with 3 stall cycles: stb held 4 cycles with stable address.
    issue(1'b0, 30'h22, 32'h0);
    i_wb_stall = 1'b1;
    cyc_step();
    i_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_stb_held", 32'(o_wb_stb), 32'd1);
      chk("rd_addr_stable", 32'(o_wb_addr), 32'h22);
      if (i == 3) i_wb_stall = 1'b0;
      cyc_step();
    end
    chk("rd_stb_low", 32'(o_wb_stb), 32'd0);
    chk("rd_cyc_hold", 32'(o_wb_cyc), 32'd1);
    i_wb_ack = 1'b1; i_wb_data = 32'hDEADBEEF;
    cyc_step();
    i_wb_ack = 1'b0; i_wb_data = '0;
    chk("rd_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("rd_rsp_data", o_rsp_data, 32'hDEADBEEF);
    chk("rd_rsp_err", 32'(o_rsp_err), 32'd0);
    cyc_step();
    chk("rd_rsp_pulse", 32'(o_rsp_valid), 32'd0);

    // Error on a read, raised while stb is being accepted.
    issue(1'b0, 30'h30, 32'h0);
    cyc_step();
    i_req_valid = 1'b0;
    chk("err_stb", 32'(o_wb_stb), 32'd1);
    i_wb_err = 1'b1; i_wb_data = 32'h12345678;
    cyc_step();
    i_wb_err = 1'b0; i_wb_data = '0;
    chk("err_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("err_rsp_err", 32'(o_rsp_err), 32'd1);
    chk("err_rsp_data", o_rsp_data, 32'd0);
    chk("err_cyc", 32'(o_wb_cyc), 32'd0);
    chk("err_ready", 32'(o_req_ready), 32'd1);
    cyc_step();

    // Timeout: no ack; cyc high for exactly 16 cycles, then error response.
    issue(1'b0, 30'h33, 32'h0);
    cyc_step();
    i_req_valid = 1'b0;
    chk("tmo_cyc_rise", 32'(o_wb_cyc), 32'd1);
    for (int i = 0; i < 15; i++) begin
      cyc_step();
      chk("tmo_cyc_held", {31'd0, o_wb_cyc && !o_rsp_valid}, 32'd1);
    end
    cyc_step();
    chk("tmo_cyc_drop", 32'(o_wb_cyc), 32'd0);
    chk("tmo_rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("tmo_rsp_err", 32'(o_rsp_err), 32'd1);
    chk("tmo_rsp_data", o_rsp_data, 32'd0);
    i_wb_ack = 1'b1; i_wb_data = 32'hBADBAD00;
    cyc_step();
    i_wb_ack = 1'b0; i_wb_data = '0;
    chk("tmo_late_ack_rsp", 32'(o_rsp_valid), 32'd0);
    chk("tmo_late_ack_cyc", 32'(o_wb_cyc), 32'd0);
    chk("tmo_ready", 32'(o_req_ready), 32'd1);

    // Ack in the very cycle the watchdog would fire: ack wins, no error.
    issue(1'b0, 30'h34, 32'h0);
    cyc_step();
    i_req_valid = 1'b0;
    repeat (15) cyc_step();
    chk("tmo_edge_cyc", 32'(o_wb_cyc), 32'd1);
    i_wb_ack = 1'b1; i_wb_data = 32'h0000A5A5;
    cyc_step();
    i_wb_ack = 1'b0; i_wb_data = '0;
    chk("tmo_edge_rsp", 32'(o_rsp_valid), 32'd1);
    chk("tmo_edge_err", 32'(o_rsp_err), 32'd0);
    chk("tmo_edge_data", o_rsp_data, 32'h0000A5A5);
    cyc_step();

    // Reset in WAIT_ACK: bus drops, no response.
    issue(1'b0, 30'h35, 32'h0);
    cyc_step();
    i_req_valid = 1'b0;
    cyc_step();
    chk("mrst_wait_ack", 32'(o_dbg_state), 32'(WAIT_ACK));
    i_reset = 1'b1;
    cyc_step();
    chk("mrst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("mrst_stb", 32'(o_wb_stb), 32'd0);
    chk("mrst_rsp", 32'(o_rsp_valid), 32'd0);
    i_reset = 1'b0;
    cyc_step();
    chk("mrst_ready", 32'(o_req_ready), 32'd1);
    chk("mrst_no_rsp", 32'(o_rsp_valid), 32'd0);

    // Back-to-back: second request waits, is accepted in the response cycle.
    issue(1'b1, 30'h40, 32'h11111111);
    cyc_step();
    issue(1'b0, 30'h44, 32'h0);
    chk("b2b_first_addr", 32'(o_wb_addr), 32'h40);
    chk("b2b_busy", 32'(o_req_ready), 32'd0);
    cyc_step();
    i_wb_ack = 1'b1;
    cyc_step();
    i_wb_ack = 1'b0;
    chk("b2b_rsp1", 32'(o_rsp_valid), 32'd1);
    chk("b2b_ready_in_rsp", 32'(o_req_ready), 32'd1);
    chk("b2b_gap_cyc", 32'(o_wb_cyc), 32'd0);
    cyc_step();
    i_req_valid = 1'b0;
    chk("b2b_cyc2", 32'(o_wb_cyc), 32'd1);
    chk("b2b_stb2", 32'(o_wb_stb), 32'd1);
    chk("b2b_addr2", 32'(o_wb_addr), 32'h44);
    chk("b2b_we2", 32'(o_wb_we), 32'd0);
    cyc_step();
    i_wb_ack = 1'b1; i_wb_data = 32'hCAFEF00D;
    cyc_step();
    i_wb_ack = 1'b0; i_wb_data = '0;
    chk("b2b_rsp2", 32'(o_rsp_valid), 32'd1);
    chk("b2b_rsp2_data", o_rsp_data, 32'hCAFEF00D);

    // Stray ack/err while idle is ignored.
    cyc_step();
    i_wb_ack = 1'b1; i_wb_err = 1'b1;
    cyc_step();
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    chk("idle_ack_rsp", 32'(o_rsp_valid), 32'd0);
    chk("idle_ack_state", 32'(o_dbg_state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
